trig_seq_ctrl: RTL and testbench
================================

Name: trig_seq_ctrl

Overview:
- Trigger configuration and sequencing controller for the capture front end.
- Owns the configuration registers for the UART RX trigger unit: baud_cnt, match and mask.
- Selects one of three trigger sources (UART, SPI, channel edge) and qualifies it with an event count.
- Issues a single trigger pulse to the capture unit, then handles capture-complete, holdoff and optional automatic re-arm.

Parameters:
- CNT_W, 8: width of the event match-count register.
- HO_W, 16: width of the holdoff counter and register.
- BAUD_RST, 434: reset value of baud_cnt (50 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  config write strobe.
- cfg_addr  in  3  config register address.
- cfg_data  in  16  config write data.
- arm  in  1  arm request pulse.
- disarm  in  1  abort pulse.
- uart_trig  in  1  single-cycle match pulse from the UART RX trigger unit.
- spi_trig  in  1  SPI trigger pulse.
- ch_trig  in  1  channel edge trigger pulse.
- cap_done  in  1  capture-complete pulse from the capture unit.
- baud_cnt  out  16  baud count to the UART RX trigger unit.
- match  out  8  match byte to the UART RX trigger unit.
- mask  out  8  mask byte to the UART RX trigger unit.
- trig_out  out  1  one-cycle trigger pulse to the capture unit.
- armed  out  1  high in ARMED.
- triggered  out  1  high in WAIT_CAP.
- cfg_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: baud_cnt=BAUD_RST, match=0, mask=0, src_sel=0, auto_rearm=0, match_n=1, holdoff=0. Outputs trig_out, armed, triggered, cfg_err all 0. State=IDLE, counters=0.
- Register map (cfg_addr):
  - 0: baud_cnt = cfg_data[15:0].
  - 1: match = cfg_data[7:0].
  - 2: mask = cfg_data[7:0].
  - 3: src_sel = cfg_data[1:0] (0 UART, 1 SPI, 2 CH, 3 OR of all); auto_rearm = cfg_data[2].
  - 4: match_n = cfg_data[CNT_W-1:0].
  - 5: holdoff = cfg_data[HO_W-1:0].
- Write acceptance:
  - Writes take effect on the clock edge where cfg_wr=1, and only in IDLE.
  - A write outside IDLE, or to address 6 or 7, changes nothing and pulses cfg_err high for the next cycle.
- The config outputs are driven directly from the registers. There is no extra latency.
- The event is the selected source as seen in that cycle. With src_sel=3, simultaneous pulses on several sources count as one event.
- match_n=0 is treated as 1.
- IDLE:
  - arm=1 moves to ARMED and clears evt_cnt.
  - Sources are ignored.
- ARMED:
  - Each event increments evt_cnt.
  - On the event that makes the count reach match_n, the next state is WAIT_CAP and trig_out is high for exactly the one following cycle (registered, 1-cycle latency from the event).
  - evt_cnt saturates and does not wrap; it is cleared on every entry to ARMED.
- WAIT_CAP:
  - triggered=1; events are ignored.
  - On cap_done: if auto_rearm=0, go to IDLE.
  - If auto_rearm=1 and holdoff=0, go to ARMED.
  - Otherwise go to HOLDOFF with ho_cnt loaded to holdoff.
- HOLDOFF:
  - ho_cnt decrements once per cycle; events are ignored.
  - When ho_cnt==1, the next state is ARMED, so the holdoff lasts exactly `holdoff` cycles.
- disarm:
  - From any state, disarm=1 goes to IDLE on the next edge and clears the counters.
  - If disarm coincides with a qualifying event, no trig_out is issued.
  - disarm has priority over arm, events and cap_done.
- arm outside IDLE is ignored.
- cap_done outside WAIT_CAP is ignored.
- Reset asserted mid-operation returns all state and registers to their reset values on that edge, including dropping any pending trig_out.

Test Plan:
- Reset check: after reset, read outputs -> baud_cnt=434, match=0, mask=0, trig_out=armed=triggered=cfg_err=0.
- Config and first-event trigger: write addr1=0xA5, addr2=0x0F, addr4=3; arm; pulse uart_trig 3 times.
  - match=0xA5 and mask=0x0F immediately after their writes.
  - armed=1.
  - trig_out is a single pulse exactly 1 cycle after the 3rd pulse, then triggered=1.
- Source select: with src_sel=1, pulse uart_trig -> no count; pulse spi_trig -> trigger. With src_sel=3, uart and ch pulsed in the same cycle with match_n=2 -> no trigger yet.
- Auto re-arm with holdoff: auto_rearm=1, holdoff=5, match_n=1. Trigger, then cap_done -> 5 cycles of HOLDOFF with armed=0, then armed=1. An event during holdoff does not trigger.
- Disarm and rejected write: in ARMED, disarm together with a qualifying event -> no trig_out, state IDLE. Then, while armed, write addr0 -> baud_cnt unchanged and cfg_err pulses once. A write to addr 7 -> cfg_err.
- Reset mid-operation and match_n=0: match_n=0, arm, one event -> trigger. Assert rst in WAIT_CAP -> all outputs and registers return to reset values on the next edge.

Source files
------------

// File: rtl/trig_seq_ctrl.sv
// Trigger configuration and sequencing controller for the capture front end.
// Holds the UART trigger config, qualifies the selected source by event count, sequences re-arm.
module trig_seq_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HO_W     = 16,
  parameter logic [15:0] BAUD_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        arm,
  input  logic        disarm,
  input  logic        uart_trig,
  input  logic        spi_trig,
  input  logic        ch_trig,
  input  logic        cap_done,
  output logic [15:0] baud_cnt,
  output logic [7:0]  match,
  output logic [7:0]  mask,
  output logic        trig_out,
  output logic        armed,
  output logic        triggered,
  output logic        cfg_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StWaitCap = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
  logic             trig_q, trig_d;
  logic             cfg_err_q, cfg_err_d;

  logic [15:0]      baud_q;
  logic [7:0]       match_q;
  logic [7:0]       mask_q;
  logic [1:0]       src_sel_q;
  logic             auto_rearm_q;
  logic [CNT_W-1:0] match_n_q;
  logic [HO_W-1:0]  holdoff_q;

  logic             wr_bad;
  logic             wr_ok;
  logic             evt;
  logic [CNT_W-1:0] match_eff;
  logic [CNT_W:0]   evt_inc;
  logic             evt_hit;

  // Writes are only legal while idle and to the six mapped registers.
  assign wr_bad = cfg_wr && ((state_q != StIdle) || (cfg_addr[2:1] == 2'b11));
  assign wr_ok  = cfg_wr && !wr_bad;

  always_comb begin
    evt = 1'b0;
    unique case (src_sel_q)
      2'd0:    evt = uart_trig;
      2'd1:    evt = spi_trig;
      2'd2:    evt = ch_trig;
      default: evt = uart_trig | spi_trig | ch_trig;
    endcase
  end

  assign match_eff = (match_n_q == '0) ? CNT_W'(1) : match_n_q;
  assign evt_inc   = {1'b0, evt_cnt_q} + (CNT_W + 1)'(1);
  assign evt_hit   = evt_inc >= {1'b0, match_eff};

  always_comb begin
    state_d   = state_q;
    evt_cnt_d = evt_cnt_q;
    ho_cnt_d  = ho_cnt_q;
    trig_d    = 1'b0;
    cfg_err_d = wr_bad;
    if (disarm) begin
      state_d   = StIdle;
      evt_cnt_d = '0;
      ho_cnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d   = StArmed;
            evt_cnt_d = '0;
          end
        end
        StArmed: begin
          if (evt) begin
            if (evt_cnt_q != '1) evt_cnt_d = evt_cnt_q + CNT_W'(1);
            if (evt_hit) begin
              state_d = StWaitCap;
              trig_d  = 1'b1;
            end
          end
        end
        StWaitCap: begin
          if (cap_done) begin
            if (!auto_rearm_q) begin
              state_d = StIdle;
            end else if (holdoff_q == '0) begin
              state_d   = StArmed;
              evt_cnt_d = '0;
            end else begin
              state_d  = StHoldoff;
              ho_cnt_d = holdoff_q;
            end
          end
        end
        default: begin
          ho_cnt_d = ho_cnt_q - HO_W'(1);
          if (ho_cnt_q == HO_W'(1)) begin
            state_d   = StArmed;
            evt_cnt_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      evt_cnt_q <= '0;
      ho_cnt_q  <= '0;
      trig_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_cnt_q <= evt_cnt_d;
      ho_cnt_q  <= ho_cnt_d;
      trig_q    <= trig_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q       <= BAUD_RST;
      match_q      <= '0;
      mask_q       <= '0;
      src_sel_q    <= '0;
      auto_rearm_q <= 1'b0;
      match_n_q    <= CNT_W'(1);
      holdoff_q    <= '0;
    end else if (wr_ok) begin
      unique case (cfg_addr)
        3'd0: baud_q    <= cfg_data;
        3'd1: match_q   <= cfg_data[7:0];
        3'd2: mask_q    <= cfg_data[7:0];
        3'd3: begin
          src_sel_q    <= cfg_data[1:0];
          auto_rearm_q <= cfg_data[2];
        end
        3'd4: match_n_q <= cfg_data[CNT_W-1:0];
        3'd5: holdoff_q <= cfg_data[HO_W-1:0];
        default: ;
      endcase
    end
  end

  assign baud_cnt  = baud_q;
  assign match     = match_q;
  assign mask      = mask_q;
  assign trig_out  = trig_q;
  assign armed     = (state_q == StArmed);
  assign triggered = (state_q == StWaitCap);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Bench for trig_seq_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a phase/count reference model.
module tb_trig_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        arm, disarm, uart_trig, spi_trig, ch_trig, cap_done;
  logic [15:0] baud_cnt;
  logic [7:0]  match, mask;
  logic        trig_out, armed, triggered, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  trig_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .arm       (arm),
    .disarm    (disarm),
    .uart_trig (uart_trig),
    .spi_trig  (spi_trig),
    .ch_trig   (ch_trig),
    .cap_done  (cap_done),
    .baud_cnt  (baud_cnt),
    .match     (match),
    .mask      (mask),
    .trig_out  (trig_out),
    .armed     (armed),
    .triggered (triggered),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 armed, 2 waiting for capture, 3 holdoff.
  int m_phase, m_evts, m_ho_left;
  int m_baud, m_match, m_mask, m_src, m_auto, m_n, m_ho;
  bit m_trig, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_evts = 0; m_ho_left = 0;
    m_baud = 434; m_match = 0; m_mask = 0; m_src = 0; m_auto = 0; m_n = 1; m_ho = 0;
    m_trig = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit ev;
    int need;
    if (rst) begin
      model_reset();
      return;
    end
    m_err  = cfg_wr && (m_phase != 0 || cfg_addr >= 6);
    m_trig = 0;
    if (cfg_wr && m_phase == 0 && cfg_addr < 6) begin
      case (cfg_addr)
        0: m_baud  = cfg_data;
        1: m_match = cfg_data & 8'hFF;
        2: m_mask  = cfg_data & 8'hFF;
        3: begin m_src = cfg_data & 3; m_auto = (cfg_data >> 2) & 1; end
        4: m_n     = cfg_data & 8'hFF;
        default: m_ho = cfg_data;
      endcase
    end
    case (m_src)
      0: ev = uart_trig;
      1: ev = spi_trig;
      2: ev = ch_trig;
      default: ev = uart_trig || spi_trig || ch_trig;
    endcase
    need = (m_n == 0) ? 1 : m_n;
    if (disarm) begin
      m_phase = 0; m_evts = 0; m_ho_left = 0;
    end else begin
      case (m_phase)
        0: if (arm) begin m_phase = 1; m_evts = 0; end
        1: if (ev) begin
             m_evts++;
             if (m_evts >= need) begin m_phase = 2; m_trig = 1; end
           end
        2: if (cap_done) begin
             if (m_auto == 0) m_phase = 0;
             else if (m_ho == 0) begin m_phase = 1; m_evts = 0; end
             else begin m_phase = 3; m_ho_left = m_ho; end
           end
        default: begin
          m_ho_left--;
          if (m_ho_left == 0) begin m_phase = 1; m_evts = 0; end
        end
      endcase
    end
  endtask

  task automatic clear_inputs();
    rst = 0; cfg_wr = 0; cfg_addr = 0; cfg_data = 0;
    arm = 0; disarm = 0; uart_trig = 0; spi_trig = 0; ch_trig = 0; cap_done = 0;
  endtask

  // Advance one clock with the current inputs and compare every output.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("baud_cnt", 32'(baud_cnt), 32'(m_baud));
    check("match", 32'(match), 32'(m_match));
    check("mask", 32'(mask), 32'(m_mask));
    check("trig_out", 32'(trig_out), 32'(m_trig));
    check("armed", 32'(armed), 32'(m_phase == 1));
    check("triggered", 32'(triggered), 32'(m_phase == 2));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    clear_inputs();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_wr = 1; cfg_addr = a; cfg_data = d;
    step();
  endtask

  task automatic pulse_arm();
    arm = 1;
    step();
  endtask

  task automatic pulse_cap();
    cap_done = 1;
    step();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    step();
    check("rst_baud", 32'(baud_cnt), 32'd434);
    check("rst_outs", {28'd0, trig_out, armed, triggered, cfg_err}, 32'd0);

    // Config and count-qualified UART trigger.
    wr(3'd1, 16'h00A5);
    check("match_wr", 32'(match), 32'hA5);
    wr(3'd2, 16'h000F);
    check("mask_wr", 32'(mask), 32'h0F);
    wr(3'd4, 16'd3);
    pulse_arm();
    check("armed_after_arm", 32'(armed), 32'd1);
    for (int i = 0; i < 3; i++) begin
      uart_trig = 1; step();
      if (i < 2) step();
    end
    check("trig_after_3rd", 32'(trig_out), 32'd1);
    step();
    check("trig_single", 32'(trig_out), 32'd0);
    check("triggered", 32'(triggered), 32'd1);
    pulse_cap();

    // Source select.
    wr(3'd3, 16'd1);
    wr(3'd4, 16'd1);
    pulse_arm();
    uart_trig = 1; step();
    check("spi_sel_ignores_uart", 32'(trig_out), 32'd0);
    spi_trig = 1; step();
    check("spi_trig", 32'(trig_out), 32'd1);
    pulse_cap();
    wr(3'd3, 16'd3);
    wr(3'd4, 16'd2);
    pulse_arm();
    uart_trig = 1; ch_trig = 1; step();
    check("or_one_event", 32'(armed), 32'd1);
    spi_trig = 1; step();
    check("or_second_event", 32'(trig_out), 32'd1);
    pulse_cap();

    // Auto re-arm with holdoff.
    wr(3'd3, 16'h0004);
    wr(3'd5, 16'd5);
    wr(3'd4, 16'd1);
    pulse_arm();
    uart_trig = 1; step();
    pulse_cap();
    for (int i = 0; i < 5; i++) begin
      check("holdoff_not_armed", 32'(armed), 32'd0);
      if (i == 2) uart_trig = 1;
      step();
    end
    check("rearmed", 32'(armed), 32'd1);
    disarm = 1; step();

    // Disarm racing an event, rejected writes.
    wr(3'd5, 16'd0);
    pulse_arm();
    uart_trig = 1; disarm = 1; step();
    check("disarm_no_trig", 32'(trig_out), 32'd0);
    check("disarm_idle", 32'(armed), 32'd0);
    pulse_arm();
    wr(3'd0, 16'h1234);
    check("locked_baud", 32'(baud_cnt), 32'd434);
    check("err_armed_wr", 32'(cfg_err), 32'd1);
    step();
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    disarm = 1; step();
    wr(3'd7, 16'hFFFF);
    check("err_addr7", 32'(cfg_err), 32'd1);

    // match_n=0 acts as 1; reset in WAIT_CAP; reset drops a pending trigger.
    wr(3'd3, 16'd0);
    wr(3'd4, 16'd0);
    pulse_arm();
    uart_trig = 1; step();
    check("n0_trig", 32'(trig_out), 32'd1);
    rst = 1; step();
    check("mid_rst_baud", 32'(baud_cnt), 32'd434);
    check("mid_rst_outs", {28'd0, trig_out, armed, triggered, cfg_err}, 32'd0);
    pulse_arm();
    uart_trig = 1; rst = 1; step();
    check("rst_drops_trig", 32'(trig_out), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      disarm    = ($urandom_range(0, 39) == 0);
      arm       = ($urandom_range(0, 4) == 0);
      uart_trig = ($urandom_range(0, 3) == 0);
      spi_trig  = ($urandom_range(0, 3) == 0);
      ch_trig   = ($urandom_range(0, 3) == 0);
      cap_done  = ($urandom_range(0, 4) == 0);
      cfg_wr    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 16'($urandom);
      if (cfg_addr == 3'd4) cfg_data = 16'($urandom_range(0, 4));
      if (cfg_addr == 3'd5) cfg_data = 16'($urandom_range(0, 6));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
